irq_encoder8x3: RTL and testbench

IRQ_ENCODER8X3 -- requirements
Module: irq_encoder8x3

---
 rtl/irq_encoder8x3_if.sv | 15 +
 rtl/irq_encoder8x3.sv | 106 ++++++++++
 tb/tb_irq_encoder8x3.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/irq_encoder8x3_if.sv
// Request/grant bundle between an interrupt consumer and irq_encoder8x3.
// The master drives requests, masks and ack; the encoder (slave) returns the grant and pending status.
interface irq_encoder8x3_if;
   logic [7:0] req;
   logic [7:0] mask;
   logic       ack;
   logic [2:0] addr;
   logic       valid;
   logic [7:0] pend;

   modport master (output req, output mask, output ack,
                   input  addr, input valid, input pend);
   modport slave  (input  req, input mask, input ack,
                   output addr, output valid, output pend);
endinterface

// File: rtl/irq_encoder8x3.sv
// 8-source edge-triggered interrupt encoder with a valid/ack grant handshake.
// Define IRQ_ENCODER8X3_RR_EN for round-robin priority; the default build uses fixed priority (7 highest).
module irq_encoder8x3 (
   input logic             clk,
   input logic             rst,
   irq_encoder8x3_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t     state_q, state_d;
   logic [7:0] req_q, req_d;
   logic [7:0] mask_q, mask_d;
   logic [7:0] pend_q, pend_d;
   logic [2:0] addr_q, addr_d;
   logic [7:0] rise, clr, elig;
   logic [2:0] sel;

`ifdef IRQ_ENCODER8X3_RR_EN
   logic [2:0] k_q, k_d;

   // Walk from lowest to highest priority so the last hit wins; k itself ranks last.
   function automatic logic [2:0] pick(input logic [7:0] e, input logic [2:0] k);
      logic [2:0] idx;
      logic [2:0] cand;
      idx = k;
      for (int j = 8; j >= 1; j--) begin
         cand = k - 3'(j);
         if (e[cand]) idx = cand;
      end
      return idx;
   endfunction

   assign sel = pick(elig, k_q);
`else
   function automatic logic [2:0] pick(input logic [7:0] e);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   assign sel = pick(elig);
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      req_d   = bus.req;
      mask_d  = bus.mask;
      clr     = 8'h00;
`ifdef IRQ_ENCODER8X3_RR_EN
      k_d     = k_q;
`endif
      rise = bus.req & ~req_q;
      elig = pend_q & ~mask_q;

      unique case (state_q)
         IDLE: begin
            if (elig != 8'h00) begin
               state_d = GRANT;
               addr_d  = sel;
            end
         end
         GRANT: begin
            if (bus.ack) begin
               state_d      = IDLE;
               clr[addr_q]  = 1'b1;
`ifdef IRQ_ENCODER8X3_RR_EN
               k_d          = addr_q;
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      // A fresh rise on the granted bit must survive the clear of that same bit.
      pend_d = (pend_q & ~clr) | rise;
   end

   always_ff @(posedge clk) begin
      mask_q <= mask_d;
      if (rst) begin
         state_q <= IDLE;
         req_q   <= 8'h00;
         pend_q  <= 8'h00;
         addr_q  <= 3'd0;
`ifdef IRQ_ENCODER8X3_RR_EN
         k_q     <= 3'd0;
`endif
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         pend_q  <= pend_d;
         addr_q  <= addr_d;
`ifdef IRQ_ENCODER8X3_RR_EN
         k_q     <= k_d;
`endif
      end
   end

   assign bus.addr  = addr_q;
   assign bus.valid = (state_q == GRANT);
   assign bus.pend  = pend_q;
endmodule

// File: tb/tb_irq_encoder8x3.sv
// Self-checking bench for irq_encoder8x3: directed scenarios plus randomized traffic against a rank-based model.
module tb_irq_encoder8x3;
   logic clk;
   logic rst;
   irq_encoder8x3_if bus ();

   irq_encoder8x3 dut (.clk(clk), .rst(rst), .bus(bus));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state, expressed as the observable registers the spec describes.
   logic [7:0] m_pend, m_prev_req, m_mask;
   logic       m_valid;
   logic [2:0] m_addr;
   int         m_k;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Rank 7 is the highest priority: the source just after k going downward; k itself ranks 0.
   function automatic int best_src(input logic [7:0] e, input int k);
      int best, best_rank, r;
      best = 0;
      best_rank = -1;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) begin
            r = (i - k + 8) % 8;
            if (r > best_rank) begin
               best_rank = r;
               best = i;
            end
         end
      end
      return best;
   endfunction

   task automatic model_edge();
      logic [7:0] rise, cleared, e;
      if (rst) begin
         m_pend = 8'h00; m_prev_req = 8'h00; m_valid = 1'b0; m_addr = 3'd0; m_k = 0;
      end else begin
         rise = bus.req & ~m_prev_req;
         cleared = m_pend;
         if (m_valid && bus.ack) cleared[m_addr] = 1'b0;
         e = m_pend & ~m_mask;
         if (!m_valid) begin
            if (e != 8'h00) begin
               m_addr  = 3'(best_src(e, m_k));
               m_valid = 1'b1;
            end
         end else if (bus.ack) begin
            m_valid = 1'b0;
`ifdef IRQ_ENCODER8X3_RR_EN
            m_k = int'(m_addr);
`endif
         end
         m_pend     = cleared | rise;
         m_prev_req = bus.req;
      end
      m_mask = bus.mask;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("valid", 32'(bus.valid), 32'(m_valid));
      check("addr",  32'(bus.addr),  32'(m_addr));
      check("pend",  32'(bus.pend),  32'(m_pend));
   endtask

   task automatic do_reset();
      rst = 1'b1; bus.req = 8'h00; bus.mask = 8'h00; bus.ack = 1'b0;
      step();
      rst = 1'b0;
   endtask

   int exp_seq [4];
   logic [7:0] rq;

   initial begin
      rst = 1'b1; bus.req = 8'h00; bus.mask = 8'h00; bus.ack = 1'b0;
      m_pend = 8'h00; m_prev_req = 8'h00; m_mask = 8'h00; m_valid = 1'b0; m_addr = 3'd0; m_k = 0;
      #2;

      // Single request, one grant, no repeat while held.
      do_reset();
      check("rst_valid", 32'(bus.valid), 32'd0);
      check("rst_addr",  32'(bus.addr),  32'd0);
      check("rst_pend",  32'(bus.pend),  32'h00);
      bus.req = 8'h04;
      step();
      check("single_pend", 32'(bus.pend), 32'h04);
      check("single_wait", 32'(bus.valid), 32'd0);
      step();
      check("single_valid", 32'(bus.valid), 32'd1);
      check("single_addr",  32'(bus.addr),  32'd2);
      bus.ack = 1'b1;
      step();
      check("single_drop", 32'(bus.valid), 32'd0);
      check("single_clr",  32'(bus.pend),  32'h00);
      bus.ack = 1'b0;
      repeat (3) step();
      check("single_norepeat", 32'(bus.valid), 32'd0);

      // Two simultaneous rises: 7 first, then 0.
      do_reset();
      bus.req = 8'h81; step(); bus.req = 8'h00; step();
      check("dual_first", 32'(bus.addr), 32'd7);
      check("dual_v1", 32'(bus.valid), 32'd1);
      bus.ack = 1'b1; step(); bus.ack = 1'b0; step();
      check("dual_second", 32'(bus.addr), 32'd0);
      check("dual_v2", 32'(bus.valid), 32'd1);
      bus.ack = 1'b1; step(); bus.ack = 1'b0;
      check("dual_pend", 32'(bus.pend), 32'h00);

      // Masked pending request is held until unmasked.
      do_reset();
      bus.req = 8'h20; bus.mask = 8'h20;
      repeat (3) step();
      check("mask_valid", 32'(bus.valid), 32'd0);
      check("mask_pend",  32'(bus.pend),  32'h20);
      bus.mask = 8'h00;
      step();
      check("unmask_wait", 32'(bus.valid), 32'd0);
      step();
      check("unmask_valid", 32'(bus.valid), 32'd1);
      check("unmask_addr",  32'(bus.addr),  32'd5);

      // Re-rise on the granted bit during ack keeps it pending and re-grants.
      do_reset();
      bus.req = 8'h08; step(); step();
      check("rerise_addr", 32'(bus.addr), 32'd3);
      bus.req = 8'h00; bus.mask = 8'hFF; step();
      check("grant_stable", 32'(bus.valid), 32'd1);
      bus.req = 8'h08; bus.mask = 8'h00; bus.ack = 1'b1; step();
      check("rerise_drop", 32'(bus.valid), 32'd0);
      check("rerise_pend", 32'(bus.pend),  32'h08);
      bus.ack = 1'b0; step();
      check("rerise_regrant", 32'(bus.valid), 32'd1);
      check("rerise_addr2",   32'(bus.addr),  32'd3);

      // Reset during a grant with ack asserted.
      do_reset();
      bus.req = 8'h10; step(); step();
      check("rstgrant_valid", 32'(bus.valid), 32'd1);
      rst = 1'b1; bus.ack = 1'b1; step();
      check("rstgrant_v", 32'(bus.valid), 32'd0);
      check("rstgrant_a", 32'(bus.addr),  32'd0);
      check("rstgrant_p", 32'(bus.pend),  32'h00);
      rst = 1'b0; bus.ack = 1'b0; step();
      check("repost_pend", 32'(bus.pend), 32'h10);
      step();
      check("repost_addr", 32'(bus.addr), 32'd4);

      // Bits 7 and 6 retriggered on every ack.
`ifdef IRQ_ENCODER8X3_RR_EN
      exp_seq = '{7, 6, 7, 6};
`else
      exp_seq = '{7, 7, 7, 7};
`endif
      do_reset();
      bus.req = 8'hC0; step(); step();
      for (int g = 0; g < 4; g++) begin
         check("prio_seq", 32'(bus.addr), 32'(exp_seq[g]));
         bus.req = 8'h00; step();
         bus.req = 8'hC0; bus.ack = 1'b1; step();
         bus.ack = 1'b0; step();
      end

      // Randomized traffic against the model.
      do_reset();
      rq = 8'h00;
      for (int c = 0; c < 3000; c++) begin
         rq = rq ^ 8'($urandom & $urandom);
         bus.req  = rq;
         bus.mask = 8'($urandom & $urandom & $urandom);
         bus.ack  = ($urandom_range(0, 2) == 0);
         rst      = ($urandom_range(0, 149) == 0);
         step();
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
